// File: rtl/axi_tx_pkg.sv
// Types shared by the AXI transmit-side channel controllers.
// arb_state_t is the two-state bus-holding FSM used by tx_rr_arbiter.
package axi_tx_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
// ptr is assumed to be in [0, N-1].
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int unsigned off = 0; off < N; off++) begin
            // ptr + off < 2N, so one conditional subtract gives the modulo.
            sum = {1'b0, ptr} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(N)) begin
                sum = sum - (ID_W+1)'(N);
            end
            idx = sum[ID_W-1:0];
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/tx_rr_arbiter.sv
// Round-robin arbiter sharing one registered VALID/READY transmit channel among N requesters.
// The winning beat is registered and held on the bus until READY completes the handshake.
module tx_rr_arbiter
    import axi_tx_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned ID_W  = $clog2(N)
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    output logic [N-1:0]       req_ready,
    output logic               VALID,
    output logic [WIDTH-1:0]   xDATA,
    output logic [ID_W-1:0]    xID,
    input  logic               READY,
    output logic               busy
);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [N-1:0]     gnt_onehot;
    logic [ID_W-1:0]  gnt_idx;
    logic             any;
    logic             load;
    logic             grant;
    logic [WIDTH-1:0] win_data;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign load  = (state_q == ARB_IDLE) || READY;
    assign grant = load && any;

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_onehot[i]) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (grant) begin
            state_d = ARB_SEND;
            data_d  = win_data;
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (load) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    // Gated by reset so no source believes a beat was taken while the register is held clear.
    assign req_ready = (grant && ARESETn) ? gnt_onehot : '0;
    assign VALID     = (state_q == ARB_SEND);
    assign busy      = VALID;
    assign xDATA     = data_q;
    assign xID       = id_q;

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Bench for tx_rr_arbiter: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a behavioural model of the bus beat and rotation pointer.
module tb_tx_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           ACLK;
    logic           ARESETn;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           VALID;
    logic [W-1:0]   xDATA;
    logic [1:0]     xID;
    logic           READY;
    logic           busy;

    tx_rr_arbiter #(
        .N     (N),
        .WIDTH (W)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .VALID     (VALID),
        .xDATA     (xDATA),
        .xID       (xID),
        .READY     (READY),
        .busy      (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Model of what is on the bus and where the next search starts.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    int           m_ptr;

    logic         obs_valid;
    logic [W-1:0] obs_data;
    int           obs_id;
    logic [N-1:0] obs_rdy;
    int           hs_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int off = 0; off < N; off++) begin
            if (v[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    // Called at a negedge; drives one cycle, checks outputs, advances the model, returns at next negedge.
    task automatic cycle(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] d,
                         input logic r);
        int           k;
        logic         ld;
        logic [N-1:0] exp_rdy;
        ARESETn   = rst;
        req_valid = v;
        req_data  = d;
        READY     = r;
        if (!rst) m_reset();
        #1;
        obs_valid = VALID;
        obs_data  = xDATA;
        obs_id    = int'(xID);
        obs_rdy   = req_ready;
        k  = pick(v, m_ptr);
        ld = !m_valid || r;
        exp_rdy = '0;
        if (rst && ld && k >= 0) exp_rdy[k] = 1'b1;
        chk("VALID", 32'(VALID), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid));
        chk("xDATA", 32'(xDATA), 32'(m_data));
        chk("xID", 32'(xID), 32'(m_id));
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (VALID && READY) hs_q.push_back(int'(xID));
        @(posedge ACLK);
        if (rst && ld) begin
            if (k >= 0) begin
                m_valid = 1'b1;
                m_data  = d[k*W +: W];
                m_id    = k;
                m_ptr   = (k + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge ACLK);
    endtask

    task automatic chk_hs(input string name, input int n, input int e[6]);
        chk({name, "_count"}, 32'(hs_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk(name, (i < hs_q.size()) ? 32'(hs_q[i]) : 32'hFFFF_FFFF, 32'(e[i]));
        end
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom};
    endfunction

    initial begin
        int e_fair[6];
        int e_skip[6];
        e_fair = '{0, 1, 2, 3, 0, 1};
        e_skip = '{0, 1, 3, 0, 0, 0};
        ARESETn   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        READY     = 1'b0;
        m_reset();
        @(negedge ACLK);

        // Reset holds everything clear even with every requester pending.
        cycle(1'b0, 4'b1111, rnd_data(), 1'b0);
        chk("rst_VALID", 32'(obs_valid), 32'd0);
        chk("rst_xDATA", 32'(obs_data), 32'd0);
        chk("rst_req_ready", 32'(obs_rdy), 32'd0);

        // Full rotation from ptr=0.
        hs_q.delete();
        repeat (6) cycle(1'b1, 4'b1111, rnd_data(), 1'b1);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk_hs("fair_seq", 6, e_fair);

        // Rotation skips the idle requester 2.
        cycle(1'b0, '0, '0, 1'b0);
        hs_q.delete();
        repeat (4) cycle(1'b1, 4'b1011, rnd_data(), 1'b1);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk_hs("skip_seq", 4, e_skip);

        // Single requester, back-to-back beats with no VALID gap.
        cycle(1'b1, 4'b0000, '0, 1'b1);
        cycle(1'b1, 4'b0100, 32'h00A5_0000, 1'b1);
        cycle(1'b1, 4'b0100, 32'h005A_0000, 1'b1);
        chk("b2b_VALID0", 32'(obs_valid), 32'd1);
        chk("b2b_xDATA0", 32'(obs_data), 32'hA5);
        chk("b2b_xID0", 32'(obs_id), 32'd2);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("b2b_VALID1", 32'(obs_valid), 32'd1);
        chk("b2b_xDATA1", 32'(obs_data), 32'h5A);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("b2b_drain", 32'(obs_valid), 32'd0);

        // Backpressure: beat held for 5 cycles, no new grant while stalled.
        cycle(1'b1, 4'b0010, 32'h0000_3C00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'b0010, 32'h0000_FF00, 1'b0);
            chk("bp_VALID", 32'(obs_valid), 32'd1);
            chk("bp_xDATA", 32'(obs_data), 32'h3C);
            chk("bp_xID", 32'(obs_id), 32'd1);
            chk("bp_req_ready", 32'(obs_rdy), 32'd0);
        end
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("bp_hs_VALID", 32'(obs_valid), 32'd1);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("bp_after_VALID", 32'(obs_valid), 32'd0);

        // Asynchronous reset while a beat is stalled, then the pointer restarts at 0.
        cycle(1'b1, 4'b1000, 32'h7700_0000, 1'b0);
        cycle(1'b1, 4'b0000, '0, 1'b0);
        chk("mid_VALID_before", 32'(obs_valid), 32'd1);
        cycle(1'b0, 4'b1111, rnd_data(), 1'b0);
        chk("mid_VALID_async", 32'(obs_valid), 32'd0);
        cycle(1'b1, 4'b1111, 32'h4433_2211, 1'b1);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("mid_next_xID", 32'(obs_id), 32'd0);
        chk("mid_next_xDATA", 32'(obs_data), 32'h11);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic rst;
            rst = ($urandom_range(0, 199) != 0);
            cycle(rst, N'($urandom), rnd_data(), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_rr_arbiter.md
# tx_rr_arbiter

Round-robin arbiter that shares one VALID/READY transmit channel among N local requesters. Each requester presents a beat with its own valid/ready handshake. The arbiter picks a winner fairly, registers that beat onto the bus, and holds VALID, xDATA and xID stable until the receiver asserts READY. It sits between the write/read data sources of a master and the AXI channel wires, and its register stage keeps the outputs glitch-free.

## Interface
Parameters:
- N, 4, number of requesters; must be ≥ 2
- WIDTH, 8, data width per beat
- ID_W, $clog2(N), localparam; width of the requester index

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- req_valid  in  N  requester i has a beat pending; must not depend on req_ready
- req_data  in  N*WIDTH  beat of requester i, in bits [i*WIDTH +: WIDTH]
- req_ready  out  N  one-hot or zero; beat of requester i is taken this cycle
- VALID  out  1  bus valid
- xDATA  out  WIDTH  bus data
- xID  out  ID_W  index of the requester that owns the current bus beat
- READY  in  1  bus ready from the receiver
- busy  out  1  high whenever VALID is high

## Operation
- States: ARB_IDLE (VALID=0) and ARB_SEND (VALID=1, beat held).
- Load enable: `load = (state==ARB_IDLE) || (state==ARB_SEND && READY)`.
- Arbitration is combinational over req_valid, searching from ptr upward and wrapping modulo N. The first set bit is the winner k.
- When load is high and any req_valid is set:
  - req_ready[k]=1 in the same cycle.
  - At the clock edge: xDATA←req_data[k], xID←k, VALID←1, ptr←(k+1) mod N, state→ARB_SEND.
- When load is high and no req_valid is set: VALID←0 and state→ARB_IDLE. xDATA and xID keep their last values.
- ARB_SEND with READY=0: every output is frozen and every req_ready bit is 0. VALID never drops without a handshake.
- Back-to-back transfers: a handshake and a new grant can happen in the same cycle, giving one beat per cycle.
- ptr advances only on a grant. Idle cycles do not move it.
- A requester that holds req_valid continuously waits at most N-1 grants.

## Timing
- Reset values: VALID=0, xDATA=0, xID=0, busy=0, req_ready=0, ptr=0, state=ARB_IDLE.
- Latency: a beat accepted at edge t (req_ready high in the cycle before t) appears on VALID/xDATA from t up to the handshake edge.
- req_ready is combinational from req_valid, state and READY. There is no combinational path from READY to VALID or xDATA.
- A handshake occurs on a rising edge where VALID=1 and READY=1. The next beat or VALID=0 appears after that same edge.
- READY high while VALID=0 has no effect.
- Reset mid-transfer: VALID clears asynchronously and the in-flight beat is dropped. The source already saw req_ready, so that beat is lost by design.
- All N req_valid bits high: grants rotate ptr, ptr+1, …, wrapping from N-1 back to 0.

## Structure
- Shared package axi_tx_pkg holds the arb_state_t enum {ARB_IDLE, ARB_SEND}. The package is reusable by the other channel controllers.
- Sub-module rr_pick (combinational): inputs req[N] and ptr[ID_W]; outputs gnt_onehot[N], gnt_idx[ID_W] and any.
- The top level holds the FSM, ptr, the output register and the req_ready gating.

## Test plan
- Reset check: with ARESETn=0 and req_valid=4'b1111, expect VALID=0, xDATA=0 and req_ready=0. After release, the first grant is xID=0.
- Single requester, back-to-back: req_valid=4'b0100, data 0xA5 then 0x5A, READY=1 throughout. Expect xID=2 and xDATA 0xA5 then 0x5A on consecutive cycles with no VALID gap.
- Backpressure: one beat 0x3C from requester 1, READY=0 for 5 cycles. Expect VALID, xDATA=0x3C and xID=1 stable for all 5 cycles, req_ready=0, and a handshake on the 6th edge.
- Fairness: req_valid=4'b1111 with READY=1. Expect xID sequence 0,1,2,3,0,1.
- Fairness with skip: req_valid=4'b1011. Expect xID sequence 0,1,3,0.
- Reset mid-operation: pull ARESETn low while VALID=1 and READY=0. Expect VALID=0 immediately (asynchronously) and the next grant to start from ptr=0.
